// File: rtl/receiver_controller.sv
// 8N1 serial receiver with 16x oversampling, selectable baud divisor,
// framing-error detection and a single-byte holding register with overrun.
module receiver_controller #(
  parameter int DIV_S0 = 651,
  parameter int DIV_S1 = 326,
  parameter int DIV_S2 = 163,
  parameter int DIV_S3 = 27
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [1:0] S,
  input  logic       ser_in,
  input  logic       rd_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        sync1;
  logic        rx_s;
  logic        rx_d;
  logic [1:0]  s_lat;
  logic [15:0] div;
  logic [15:0] tcnt;
  logic [3:0]  scnt;
  logic [2:0]  bcnt;
  logic [7:0]  shreg;
  logic        tick;
  logic        go_start;
  logic        clr_scnt;
  logic        sample_bit;
  logic        commit;
  logic        ferr;

  // Two-flop synchronizer plus one history flop for edge detection
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= ser_in;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  // Divisor chosen by the baud select captured at frame start
  always_comb begin
    div = 16'(DIV_S0);
    unique case (s_lat)
      2'b00: div = 16'(DIV_S0);
      2'b01: div = 16'(DIV_S1);
      2'b10: div = 16'(DIV_S2);
      2'b11: div = 16'(DIV_S3);
    endcase
  end

  assign tick = (state != IDLE) && (tcnt == div - 16'd1);
  assign busy = (state != IDLE);

  // State register
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nx   = state;
    go_start   = 1'b0;
    clr_scnt   = 1'b0;
    sample_bit = 1'b0;
    commit     = 1'b0;
    ferr       = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_d && !rx_s) begin
          state_nx = START;
          go_start = 1'b1;
        end
      end
      START: begin
        if (tick && scnt == 4'd7) begin
          if (!rx_s) begin
            state_nx = DATA;
            clr_scnt = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DATA: begin
        if (tick && scnt == 4'd15) begin
          sample_bit = 1'b1;
          if (bcnt == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (tick && scnt == 4'd15) begin
          state_nx = IDLE;
          if (rx_s) commit = 1'b1;
          else      ferr   = 1'b1;
        end
      end
    endcase
  end

  // Tick, sample and bit counters; baud select capture
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      tcnt  <= '0;
      scnt  <= '0;
      bcnt  <= '0;
      s_lat <= '0;
    end else if (state == IDLE) begin
      tcnt <= '0;
      scnt <= '0;
      bcnt <= '0;
      if (go_start) s_lat <= S;
    end else begin
      if (tick) begin
        tcnt <= '0;
        scnt <= clr_scnt ? 4'd0 : scnt + 4'd1;
      end else begin
        tcnt <= tcnt + 16'd1;
      end
      if (sample_bit) bcnt <= bcnt + 3'd1;
    end
  end

  // Data bit shift register, indexed LSB first
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)          shreg <= '0;
    else if (sample_bit) shreg[bcnt] <= rx_s;
  end

  // Holding register, valid/overrun flags and framing-error pulse
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      data_out      <= 8'h00;
      data_valid    <= 1'b0;
      overrun       <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      framing_error <= ferr;
      if (commit) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
        if (data_valid && !rd_ack) overrun <= 1'b1;
      end else if (rd_ack) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule
